// File: rtl/boxhead_pkg.sv
// Shared types and constants for the boxhead sprite/combat blocks.
// Attack box size is shared with the attack hitbox generator.
package boxhead_pkg;

  typedef enum logic [1:0] {ALIVE, HIT, DYING, DEAD} enemy_state_t;

  localparam logic [9:0] ATK_W = 10'd16;
  localparam logic [9:0] ATK_H = 10'd16;
  localparam int FRAME_CNT_W = 6;

  localparam logic [FRAME_CNT_W-1:0] FRAME_CNT_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  // A window of 0 frames behaves like 1 frame, so both load a count of 0.
  function automatic logic [FRAME_CNT_W-1:0] frames_to_load(input logic [FRAME_CNT_W-1:0] frames);
    logic [FRAME_CNT_W-1:0] load;
    if (frames == '0) begin
      load = '0;
    end else begin
      load = frames - FRAME_CNT_ONE;
    end
    return load;
  endfunction

  // Strict 1-D span overlap in 11 bits so far edges near 1023 never wrap.
  function automatic logic span_overlap(input logic [9:0] a_pos, input logic [9:0] a_len,
                                        input logic [9:0] b_pos, input logic [9:0] b_len);
    logic [10:0] a_end;
    logic [10:0] b_end;
    a_end = {1'b0, a_pos} + {1'b0, a_len};
    b_end = {1'b0, b_pos} + {1'b0, b_len};
    return ({1'b0, a_pos} < b_end) && ({1'b0, b_pos} < a_end);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the level frame clock into a one-Clk tick on its rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic frame_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_prev <= 1'b0;
    end else begin
      frame_prev <= frame_clk;
    end
  end

  assign tick = frame_clk & ~frame_prev;

endmodule

// File: rtl/attack_hit_resolver.sv
// Per-enemy hit resolution and hit/death/respawn sequencing, paced by frame ticks.
// Define ATTACK_HIT_KILLCOUNT_EN to add the saturating Kill_Count output.
module attack_hit_resolver
  import boxhead_pkg::*;
#(
  parameter logic [9:0]             ENEMY_W        = 10'd32,
  parameter logic [9:0]             ENEMY_H        = 10'd32,
  parameter logic [3:0]             MAX_HP         = 4'd5,
  parameter logic [3:0]             DAMAGE         = 4'd1,
  parameter logic [FRAME_CNT_W-1:0] HIT_FRAMES     = 6'd8,
  parameter logic [FRAME_CNT_W-1:0] DIE_FRAMES     = 6'd16,
  parameter logic [FRAME_CNT_W-1:0] RESPAWN_FRAMES = 6'd60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       Atk_On,
  input  logic [9:0] Atk_X,
  input  logic [9:0] Atk_Y,
  input  logic [9:0] Enemy_X,
  input  logic [9:0] Enemy_Y,
  output logic [3:0] Enemy_Hp,
  output logic       Enemy_Alive,
  output logic       Hit_Flash,
  output logic       Kill_Pulse
`ifdef ATTACK_HIT_KILLCOUNT_EN
  ,
  output logic [7:0] Kill_Count
`endif
);

  localparam logic [FRAME_CNT_W-1:0] HIT_LOAD     = frames_to_load(HIT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] DIE_LOAD     = frames_to_load(DIE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] RESPAWN_LOAD = frames_to_load(RESPAWN_FRAMES);

  enemy_state_t           state;
  enemy_state_t           state_next;
  logic [3:0]             hp_next;
  logic [FRAME_CNT_W-1:0] cnt;
  logic [FRAME_CNT_W-1:0] cnt_next;
  logic                   tick;
  logic                   overlap;
  logic                   hit_now;
  logic                   kill_event;
  logic                   alive_next;
  logic                   flash_next;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign overlap = span_overlap(Atk_X, ATK_W, Enemy_X, ENEMY_W) &&
                   span_overlap(Atk_Y, ATK_H, Enemy_Y, ENEMY_H);

  // Only a fresh hit in ALIVE counts; HIT/DYING/DEAD shrug off the attack box.
  assign hit_now = tick & Atk_On & overlap & (state == ALIVE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ALIVE;
      Enemy_Hp    <= MAX_HP;
      cnt         <= '0;
      Enemy_Alive <= 1'b1;
      Hit_Flash   <= 1'b0;
      Kill_Pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      Enemy_Hp    <= hp_next;
      cnt         <= cnt_next;
      Enemy_Alive <= alive_next;
      Hit_Flash   <= flash_next;
      Kill_Pulse  <= kill_event;
    end
  end

  always_comb begin
    state_next = state;
    hp_next    = Enemy_Hp;
    cnt_next   = cnt;
    kill_event = 1'b0;
    if (tick) begin
      case (state)
        ALIVE: begin
          if (hit_now) begin
            if (DAMAGE >= Enemy_Hp) begin
              hp_next = 4'd0;
            end else begin
              hp_next = Enemy_Hp - DAMAGE;
            end
            if (hp_next == 4'd0) begin
              state_next = DYING;
              cnt_next   = DIE_LOAD;
            end else begin
              state_next = HIT;
              cnt_next   = HIT_LOAD;
            end
          end
        end
        HIT: begin
          if (cnt == '0) begin
            state_next = ALIVE;
          end else begin
            cnt_next = cnt - FRAME_CNT_ONE;
          end
        end
        DYING: begin
          if (cnt == '0) begin
            state_next = DEAD;
            cnt_next   = RESPAWN_LOAD;
            kill_event = 1'b1;
          end else begin
            cnt_next = cnt - FRAME_CNT_ONE;
          end
        end
        DEAD: begin
          if (cnt == '0) begin
            state_next = ALIVE;
            hp_next    = MAX_HP;
          end else begin
            cnt_next = cnt - FRAME_CNT_ONE;
          end
        end
        default: begin
          state_next = ALIVE;
        end
      endcase
    end
  end

  // Output flags follow the next state so they land together with it.
  always_comb begin
    alive_next = (state_next == ALIVE) || (state_next == HIT);
    flash_next = (state_next == HIT);
  end

`ifdef ATTACK_HIT_KILLCOUNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Kill_Count <= 8'd0;
    end else if (Kill_Pulse && (Kill_Count != 8'hFF)) begin
      Kill_Count <= Kill_Count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_attack_hit_resolver.sv
// Directed scoreboard bench for attack_hit_resolver; covers Kill_Count when
// ATTACK_HIT_KILLCOUNT_EN is defined.
module tb_attack_hit_resolver;

  localparam int S_ALIVE = 0;
  localparam int S_HIT   = 1;
  localparam int S_DYING = 2;
  localparam int S_DEAD  = 3;

  typedef struct packed {
    logic [3:0] hp;
    logic       alive;
    logic       flash;
    logic       kill;
  } obs_t;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic       Atk_On;
  logic [9:0] Atk_X;
  logic [9:0] Atk_Y;
  logic [9:0] Enemy_X;
  logic [9:0] Enemy_Y;
  logic [3:0] Enemy_Hp;
  logic       Enemy_Alive;
  logic       Hit_Flash;
  logic       Kill_Pulse;
`ifdef ATTACK_HIT_KILLCOUNT_EN
  logic [7:0] Kill_Count;
`endif

  obs_t exp_q[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   kill_seen = 0;

  int   m_state;
  int   m_hp;
  int   m_cnt;
  int   m_kills;
  int   m_pulses;
  bit   m_kill;

  attack_hit_resolver dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .Atk_On      (Atk_On),
    .Atk_X       (Atk_X),
    .Atk_Y       (Atk_Y),
    .Enemy_X     (Enemy_X),
    .Enemy_Y     (Enemy_Y),
    .Enemy_Hp    (Enemy_Hp),
    .Enemy_Alive (Enemy_Alive),
    .Hit_Flash   (Hit_Flash),
    .Kill_Pulse  (Kill_Pulse)
`ifdef ATTACK_HIT_KILLCOUNT_EN
    ,
    .Kill_Count  (Kill_Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Kill_Pulse === 1'b1) kill_seen++;
  end

  function automatic bit model_overlap();
    int ax, ay, ex, ey;
    ax = Atk_X;
    ay = Atk_Y;
    ex = Enemy_X;
    ey = Enemy_Y;
    return (ax < ex + 32) && (ex < ax + 16) && (ay < ey + 32) && (ey < ay + 16);
  endfunction

  function automatic void model_reset();
    m_state = S_ALIVE;
    m_hp    = 5;
    m_cnt   = 0;
    m_kill  = 1'b0;
    m_kills = 0;
  endfunction

  function automatic void model_step();
    m_kill = 1'b0;
    case (m_state)
      S_ALIVE: begin
        if ((Atk_On === 1'b1) && model_overlap()) begin
          m_hp = (m_hp > 1) ? m_hp - 1 : 0;
          if (m_hp == 0) begin
            m_state = S_DYING;
            m_cnt   = 15;
          end else begin
            m_state = S_HIT;
            m_cnt   = 7;
          end
        end
      end
      S_HIT: begin
        if (m_cnt == 0) m_state = S_ALIVE;
        else m_cnt--;
      end
      S_DYING: begin
        if (m_cnt == 0) begin
          m_state = S_DEAD;
          m_cnt   = 59;
          m_kill  = 1'b1;
          m_pulses++;
          if (m_kills < 255) m_kills++;
        end else begin
          m_cnt--;
        end
      end
      default: begin
        if (m_cnt == 0) begin
          m_state = S_ALIVE;
          m_hp    = 5;
        end else begin
          m_cnt--;
        end
      end
    endcase
  endfunction

  task automatic push_expect();
    obs_t e;
    e.hp    = 4'(m_hp);
    e.alive = (m_state == S_ALIVE) || (m_state == S_HIT);
    e.flash = (m_state == S_HIT);
    e.kill  = m_kill;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_output(input string tag);
    obs_t o;
    obs_t e;
    o = {Enemy_Hp, Enemy_Alive, Hit_Flash, Kill_Pulse};
    check_cnt++;
    assert (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (o === e) pass_cnt++;
      else $error("[TB] FAIL %s observed hp/alive/flash/kill=%h expected=%h", tag, o, e);
    end else begin
      $error("[TB] FAIL %s observed=%h expected=<empty scoreboard>", tag, o);
    end
  endtask

  task automatic apply_stimulus(input bit on, input int ax, input int ay, input int ex, input int ey);
    @(negedge Clk);
    Atk_On  = on;
    Atk_X   = 10'(ax);
    Atk_Y   = 10'(ay);
    Enemy_X = 10'(ex);
    Enemy_Y = 10'(ey);
  endtask

  // One frame: rising frame_clk (tick), then a quiet cycle that must change nothing.
  task automatic do_tick(input string tag);
    @(negedge Clk);
    frame_clk = 1'b1;
    model_step();
    push_expect();
    @(posedge Clk);
    #1 check_output(tag);
    @(negedge Clk);
    frame_clk = 1'b0;
    m_kill = 1'b0;
    push_expect();
    @(posedge Clk);
    #1 check_output({tag, "_quiet"});
  endtask

  task automatic async_reset(input string tag);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 model_reset();
    push_expect();
    check_output(tag);
`ifdef ATTACK_HIT_KILLCOUNT_EN
    check({tag, "_count"}, Kill_Count, 0);
`endif
    frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic run_kill(input string tag);
    apply_stimulus(1, 100, 100, 110, 90);
    repeat (37) do_tick({tag, "_drain"});
    apply_stimulus(0, 100, 100, 110, 90);
    repeat (16) do_tick({tag, "_dying"});
    repeat (60) do_tick({tag, "_dead"});
  endtask

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    Atk_On    = 1'b0;
    Atk_X     = '0;
    Atk_Y     = '0;
    Enemy_X   = '0;
    Enemy_Y   = '0;
    m_pulses  = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    push_expect();
    check_output("reset_hold");
    Reset_n = 1'b1;

    apply_stimulus(0, 100, 100, 110, 90);
    repeat (10) do_tick("idle");
    check("idle_hp", Enemy_Hp, 5);
    check("idle_alive", Enemy_Alive, 1);
    check("idle_no_kill", kill_seen, 0);

    apply_stimulus(1, 100, 100, 110, 90);
    do_tick("hit1");
    check("hit1_hp", Enemy_Hp, 4);
    check("hit1_flash", Hit_Flash, 1);
    repeat (7) do_tick("hit_window");
    check("window_hp", Enemy_Hp, 4);
    check("window_flash", Hit_Flash, 1);
    do_tick("window_end");
    check("window_end_flash", Hit_Flash, 0);
    check("window_end_hp", Enemy_Hp, 4);
    do_tick("hit2");
    check("hit2_hp", Enemy_Hp, 3);
    repeat (3) do_tick("hit2_window");
    async_reset("reset_mid_hit");

    apply_stimulus(1, 100, 100, 116, 100);
    do_tick("touch_x");
    apply_stimulus(1, 100, 100, 100, 116);
    do_tick("touch_y");
    check("touch_hp", Enemy_Hp, 5);
    apply_stimulus(1, 100, 100, 115, 100);
    do_tick("overlap_x");
    check("overlap_hp", Enemy_Hp, 4);
    apply_stimulus(0, 100, 100, 115, 100);
    repeat (8) do_tick("recover");

    apply_stimulus(1, 1015, 100, 5, 100);
    repeat (2) do_tick("wrap_x");
    apply_stimulus(1, 100, 1015, 100, 5);
    repeat (2) do_tick("wrap_y");
    check("wrap_hp", Enemy_Hp, 4);
    async_reset("reset_clean");

    apply_stimulus(1, 100, 100, 110, 90);
    repeat (37) do_tick("drain");
    check("drain_alive", Enemy_Alive, 0);
    check("drain_hp", Enemy_Hp, 0);
    apply_stimulus(0, 100, 100, 110, 90);
    repeat (8) do_tick("dying_part");
    async_reset("reset_mid_dying");

    run_kill("kill1");
    check("kill1_pulses", kill_seen, m_pulses);
    check("respawn_alive", Enemy_Alive, 1);
    check("respawn_hp", Enemy_Hp, 5);

`ifdef ATTACK_HIT_KILLCOUNT_EN
    run_kill("kill2");
    run_kill("kill3");
    @(negedge Clk);
    check("kill_count3", Kill_Count, 3);
    check("kill_count_model", Kill_Count, m_kills);
    check("kill3_pulses", kill_seen, m_pulses);
`endif

    apply_stimulus(1, 100, 100, 110, 90);
    repeat (37) do_tick("drain2");
    apply_stimulus(0, 100, 100, 110, 90);
    repeat (15) do_tick("dying2");
    @(negedge Clk);
    frame_clk = 1'b1;
    model_step();
    push_expect();
    @(posedge Clk);
    #1 check_output("kill_edge");
    #1 Reset_n = 1'b0;
    #1 model_reset();
    push_expect();
    check_output("kill_dropped");
`ifdef ATTACK_HIT_KILLCOUNT_EN
    check("kill_count_cleared", Kill_Count, 0);
`endif
    frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    push_expect();
    check_output("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/attack_hit_resolver.md
Name: attack_hit_resolver

Overview:
- Receiving end of the player attack hitbox: takes the 16x16 attack box (position plus on flag) and one enemy's bounding box.
- Resolves overlap once per frame tick and applies damage, then runs the enemy's hit, death and respawn state machine.
- Drives enemy HP, alive and flash flags, and a kill pulse to the enemy sprite and score logic.
- One instance per enemy, clocked by Clk.

Parameters:
- ENEMY_W, 10'd32, enemy bounding-box width in pixels
- ENEMY_H, 10'd32, enemy bounding-box height in pixels
- MAX_HP, 4'd5, HP loaded at reset and at respawn
- DAMAGE, 4'd1, HP removed per registered hit
- HIT_FRAMES, 6'd8, frame ticks of invulnerability/flash after a non-lethal hit
- DIE_FRAMES, 6'd16, frame ticks spent in DYING
- RESPAWN_FRAMES, 6'd60, frame ticks spent in DEAD before respawn

Ports:
- Clk  input  1  50 MHz system clock
- Reset_n  input  1  reset, asynchronous, active-low
- frame_clk  input  1  ~60 Hz frame clock, level signal, synchronous to Clk
- Atk_On  input  1  attack box currently active
- Atk_X  input  10  attack box top-left X
- Atk_Y  input  10  attack box top-left Y
- Enemy_X  input  10  enemy box top-left X
- Enemy_Y  input  10  enemy box top-left Y
- Enemy_Hp  output  4  current HP
- Enemy_Alive  output  1  high in ALIVE and HIT
- Hit_Flash  output  1  high in HIT
- Kill_Pulse  output  1  single-Clk pulse on entry to DEAD

Behaviour:
- Reset values (Reset_n low, async): state ALIVE, Enemy_Hp=MAX_HP, Enemy_Alive=1, Hit_Flash=0, Kill_Pulse=0, frame counter=0, edge-detect register=0.
- Tick: tick=1 for exactly one Clk when frame_clk was 0 last cycle and is 1 now (one register plus compare). All state changes except reset happen only on tick cycles.
- Overlap, evaluated in 11-bit unsigned to avoid wrap near 1023:
  - Atk_X < Enemy_X+ENEMY_W, and Enemy_X < Atk_X+16.
  - Atk_Y < Enemy_Y+ENEMY_H, and Enemy_Y < Atk_Y+16.
  - Edges that only touch do not overlap.
- hit = tick & Atk_On & overlap & state==ALIVE.
- States:
  - ALIVE: on hit, Hp_next = Hp-DAMAGE, saturating at 0. If Hp_next==0, go to DYING with cnt=DIE_FRAMES-1; otherwise go to HIT with cnt=HIT_FRAMES-1.
  - HIT: Hit_Flash=1 and hits are ignored. On each tick, if cnt==0 go to ALIVE, else cnt--.
  - DYING: Enemy_Alive=0 and hits are ignored. On each tick, if cnt==0 go to DEAD with cnt=RESPAWN_FRAMES-1 and assert Kill_Pulse that same Clk, else cnt--.
  - DEAD: Enemy_Alive=0. On each tick, if cnt==0 go to ALIVE with Hp=MAX_HP, else cnt--.
- Outputs are registered and visible the Clk after the tick.
- A held attack over N ticks yields at most one hit per ALIVE window: the HIT window prevents per-frame drain.
- DAMAGE>=Hp is lethal.
- A parameter value of 0 frames is treated as 1.
- Reset mid-operation returns immediately to the reset values; a pending Kill_Pulse is dropped.

Optional Feature:
- Macro: ATTACK_HIT_KILLCOUNT_EN.
- Defined: adds output Kill_Count [7:0].
  - Reset 0.
  - Increments on each Kill_Pulse, saturating at 255.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- boxhead_pkg holds:
  - typedef enum logic [1:0] {ALIVE, HIT, DYING, DEAD} enemy_state_t
  - constants ATK_W=10'd16 and ATK_H=10'd16, shared with the attack hitbox generator
  - localparam FRAME_CNT_W=6
- One sub-module, frame_tick_gen (Clk, Reset_n, frame_clk -> tick). It is reusable by other frame-paced blocks.

Test Plan:
- Reset release, Atk_On=0, 10 ticks -> Enemy_Hp=5, Enemy_Alive=1, Hit_Flash=0, Kill_Pulse never high.
- Atk (100,100) on, enemy (110,90), one tick -> Hp=4, Hit_Flash=1 for 8 ticks then 0; attack held through the window -> Hp stays 4, next tick after the window -> Hp=3.
- Edge-touch: Atk_X=100, Enemy_X=116, Y fully overlapping, Atk_On=1 -> no hit, Hp stays 5. Repeat with Enemy_X=115 -> hit, Hp=4.
- Five separated hits -> state DYING after the fifth, Enemy_Alive=0; 16 ticks later Kill_Pulse high exactly 1 Clk; 60 ticks later Alive=1, Hp=5.
- Wrap case: Atk_X=1015, enemy X=5 -> no overlap, Hp unchanged.
- Reset_n pulled low mid-HIT and mid-DYING -> outputs return to reset values asynchronously. With ATTACK_HIT_KILLCOUNT_EN, 3 kills -> Kill_Count=3, and reset clears it.
